// File: rtl/icache_control.sv
// Direct-mapped 16-frame, one-word-per-frame instruction cache in front of memory_control.
// Define ICACHE_FWD_EN to forward fill data to the datapath in the fill cycle.
module icache_control (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic [31:0] imemload,
  output logic        ihit,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic [31:0] iload,
  input  logic        iwait
);

  typedef enum logic {IDLE = 1'b0, FETCH = 1'b1} state_t;

  state_t      state;
  logic [31:0] miss_addr;
  logic [15:0] valid;
  logic [25:0] tags [16];
  logic [31:0] data [16];

  logic [3:0]  req_idx;
  logic [25:0] req_tag;
  logic [3:0]  fill_idx;
  logic        lookup_hit;
  logic        fill_done;
  logic        fwd_hit;

  // Byte offset never selects anything: frames hold exactly one word.
  logic        unused_byte_offset;
  assign unused_byte_offset = ^imemaddr[1:0];

  assign req_idx  = imemaddr[5:2];
  assign req_tag  = imemaddr[31:6];
  assign fill_idx = miss_addr[5:2];

  assign lookup_hit = (state == IDLE) && imemREN && valid[req_idx] &&
                      (tags[req_idx] == req_tag);
  assign fill_done  = (state == FETCH) && !iwait;

`ifdef ICACHE_FWD_EN
  assign fwd_hit = fill_done && imemREN && (imemaddr[31:2] == miss_addr[31:2]);
`else
  assign fwd_hit = 1'b0;
`endif

  always_comb begin
    ihit     = lookup_hit | fwd_hit;
    imemload = '0;
    if (lookup_hit) begin
      imemload = data[req_idx];
    end else if (fwd_hit) begin
      imemload = iload;
    end
  end

  // Fill request is a pure function of state, so reset drops it immediately.
  assign iREN  = (state == FETCH);
  assign iaddr = iREN ? miss_addr : '0;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      miss_addr <= '0;
      valid     <= '0;
      for (int i = 0; i < 16; i++) begin
        tags[i] <= '0;
        data[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (imemREN && !lookup_hit) begin
            miss_addr <= {imemaddr[31:2], 2'b00};
            state     <= FETCH;
          end
        end
        FETCH: begin
          // The fill completes even if the datapath has moved on or dropped its request.
          if (!iwait) begin
            valid[fill_idx] <= 1'b1;
            tags[fill_idx]  <= miss_addr[31:6];
            data[fill_idx]  <= iload;
            state           <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
